// File: rtl/solver_arbiter_if.sv
// Bundle of requester, solver and response signals shared by solver_arbiter and its environment.
// The slave modport is the arbiter's view and the master modport is the surrounding system's view.
interface solver_arbiter_if;
    logic [1:0]   req_valid;
    logic [647:0] req_puzzle;
    logic [1:0]   req_ready;
    logic [323:0] solver_puzzle;
    logic         solver_start;
    logic         solver_abort;
    logic         solver_solution;
    logic         solver_give_up;
    logic [323:0] solver_grid;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [1:0]   rsp_status;
    logic [323:0] rsp_grid;
    logic [9:0]   num_solved;
    logic [9:0]   num_failed;
    logic [31:0]  busy_cycles;

    modport slave (
        input  req_valid, req_puzzle, solver_solution, solver_give_up, solver_grid, rsp_ready,
        output req_ready, solver_puzzle, solver_start, solver_abort,
        output rsp_valid, rsp_id, rsp_status, rsp_grid, num_solved, num_failed, busy_cycles
    );

    modport master (
        output req_valid, req_puzzle, solver_solution, solver_give_up, solver_grid, rsp_ready,
        input  req_ready, solver_puzzle, solver_start, solver_abort,
        input  rsp_valid, rsp_id, rsp_status, rsp_grid, num_solved, num_failed, busy_cycles
    );
endinterface

// File: rtl/solver_arbiter.sv
// Round-robin arbiter sharing one sudoku solver between two requesters, with a RUN watchdog
// and saturating outcome counters.
module solver_arbiter #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    solver_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int unsigned     WDW       = (TIMEOUT > 32'd2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0]  WDOG_LAST = WDW'(TIMEOUT - 32'd1);
    localparam logic [9:0]      CNT_MAX   = 10'h3FF;
    localparam logic [31:0]     BUSY_MAX  = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_SOLVED  = 2'b01;
    localparam logic [1:0] ST_GAVE_UP = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [323:0]   puzzle_q, puzzle_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [1:0]     rsp_status_q, rsp_status_d;
    logic [323:0]   rsp_grid_q, rsp_grid_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic [9:0]     solved_q, solved_d;
    logic [9:0]     failed_q, failed_d;
    logic [31:0]    busy_q, busy_d;

    logic           grant_valid_s;
    logic           grant_id_s;
    logic [1:0]     req_ready_s;
    logic           abort_s;

    // Grant selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_valid_s = |bus.req_valid;
        grant_id_s    = 1'b0;
        case (bus.req_valid)
            2'b01:   grant_id_s = 1'b0;
            2'b10:   grant_id_s = 1'b1;
            2'b11:   grant_id_s = ~last_grant_q;
            default: grant_id_s = 1'b0;
        endcase
        if ((state_q == S_IDLE) && grant_valid_s) begin
            req_ready_s = grant_id_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Abort only when the watchdog expires and the solver has not answered in that same cycle.
    always_comb begin
        if ((state_q == S_RUN) && !bus.solver_solution && !bus.solver_give_up &&
            (wdog_q == WDOG_LAST)) begin
            abort_s = 1'b1;
        end else begin
            abort_s = 1'b0;
        end
    end

    // Next-state and next-register computation for the whole arbiter.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        puzzle_d     = puzzle_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_status_d = rsp_status_q;
        rsp_grid_d   = rsp_grid_q;
        wdog_d       = wdog_q;
        solved_d     = solved_q;
        failed_d     = failed_q;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                if (grant_valid_s) begin
                    puzzle_d     = grant_id_s ? bus.req_puzzle[647:324] : bus.req_puzzle[323:0];
                    rsp_id_d     = grant_id_s;
                    last_grant_d = grant_id_s;
                    state_d      = S_START;
                end else begin
                    state_d      = S_IDLE;
                end
            end

            S_START: begin
                wdog_d  = {WDW{1'b0}};
                state_d = S_RUN;
            end

            S_RUN: begin
                busy_d = (busy_q == BUSY_MAX) ? busy_q : busy_q + 32'd1;
                wdog_d = wdog_q + {{(WDW-1){1'b0}}, 1'b1};
                if (bus.solver_solution) begin
                    rsp_grid_d   = bus.solver_grid;
                    rsp_status_d = ST_SOLVED;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else if (bus.solver_give_up) begin
                    rsp_grid_d   = bus.solver_grid;
                    rsp_status_d = ST_GAVE_UP;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    rsp_grid_d   = 324'd0;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    state_d      = S_RUN;
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if (rsp_status_q == ST_SOLVED) begin
                        solved_d = (solved_q == CNT_MAX) ? solved_q : solved_q + 10'd1;
                    end else begin
                        failed_d = (failed_q == CNT_MAX) ? failed_q : failed_q + 10'd1;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end

            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset drops any in-flight job silently and favours requester 0 on the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            puzzle_q     <= 324'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_status_q <= 2'b00;
            rsp_grid_q   <= 324'd0;
            wdog_q       <= {WDW{1'b0}};
            solved_q     <= 10'd0;
            failed_q     <= 10'd0;
            busy_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            puzzle_q     <= puzzle_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_status_q <= rsp_status_d;
            rsp_grid_q   <= rsp_grid_d;
            wdog_q       <= wdog_d;
            solved_q     <= solved_d;
            failed_q     <= failed_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready     = req_ready_s;
    assign bus.solver_puzzle = puzzle_q;
    assign bus.solver_start  = (state_q == S_START);
    assign bus.solver_abort  = abort_s;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_status    = rsp_status_q;
    assign bus.rsp_grid      = rsp_grid_q;
    assign bus.num_solved    = solved_q;
    assign bus.num_failed    = failed_q;
    assign bus.busy_cycles   = busy_q;

endmodule

// File: tb/tb_solver_arbiter.sv
// Directed bench for solver_arbiter: a small grant/counter model plus a response scoreboard,
// checked with immediate assertions.
module tb_solver_arbiter;

    localparam int TO = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    solver_arbiter_if bus_if ();

    solver_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic         id;
        logic [1:0]   status;
        logic [323:0] grid;
    } rsp_t;

    rsp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        model_last;
    logic [9:0]  m_solved;
    logic [9:0]  m_failed;
    logic [31:0] m_busy;

    task automatic check(input string tag, input logic [323:0] obs, input logic [323:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [323:0] rand_grid();
        logic [323:0] v;
        v = 324'd0;
        for (int i = 0; i < 11; i++) v = (v << 32) | 324'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".num_solved"},  324'(bus_if.num_solved),  324'(m_solved));
        check({tag, ".num_failed"},  324'(bus_if.num_failed),  324'(m_failed));
        check({tag, ".busy_cycles"}, 324'(bus_if.busy_cycles), 324'(m_busy));
    endtask

    task automatic check_reset_outputs();
        check("rst.req_ready",     324'(bus_if.req_ready),    324'(0));
        check("rst.solver_puzzle", bus_if.solver_puzzle,      324'(0));
        check("rst.solver_start",  324'(bus_if.solver_start), 324'(0));
        check("rst.solver_abort",  324'(bus_if.solver_abort), 324'(0));
        check("rst.rsp_valid",     324'(bus_if.rsp_valid),    324'(0));
        check("rst.rsp_id",        324'(bus_if.rsp_id),       324'(0));
        check("rst.rsp_status",    324'(bus_if.rsp_status),   324'(0));
        check("rst.rsp_grid",      bus_if.rsp_grid,           324'(0));
        check_counters("rst");
    endtask

    // One complete job: accept, start, RUN until done/timeout, response with optional backpressure.
    task automatic do_job(input logic [1:0] valid, input bit hold, input int done_at,
                          input logic sol, input logic gu, input int rsp_delay);
        logic [323:0] p0, p1, grid, exp_puz;
        logic         g;
        rsp_t         e;
        int           r;
        bit           fin, hit;

        p0   = rand_grid();
        p1   = rand_grid();
        grid = rand_grid();
        g    = (valid == 2'b11) ? ~model_last : valid[1];

        bus_if.req_puzzle = {p1, p0};
        bus_if.req_valid  = valid;
        #1;
        check("accept.req_ready", 324'(bus_if.req_ready), g ? 324'(2) : 324'(1));
        check("accept.rsp_valid", 324'(bus_if.rsp_valid), 324'(0));
        exp_puz    = g ? p1 : p0;
        model_last = g;
        e.id = g;
        if (done_at >= 1 && done_at <= TO && sol) begin
            e.status = 2'b01; e.grid = grid;
        end else if (done_at >= 1 && done_at <= TO && gu) begin
            e.status = 2'b10; e.grid = grid;
        end else begin
            e.status = 2'b11; e.grid = 324'd0;
        end
        sb_q.push_back(e);

        tick();
        if (!hold) bus_if.req_valid = 2'b00;
        bus_if.solver_give_up = 1'b1;
        bus_if.solver_grid    = rand_grid();
        #1;
        check("start.solver_start",  324'(bus_if.solver_start), 324'(1));
        check("start.solver_puzzle", bus_if.solver_puzzle,      exp_puz);
        check("start.req_ready",     324'(bus_if.req_ready),    324'(0));

        r   = 0;
        fin = 1'b0;
        while (!fin) begin
            tick();
            r++;
            hit = (r == done_at);
            bus_if.solver_solution = hit & sol;
            bus_if.solver_give_up  = hit & gu;
            bus_if.solver_grid     = hit ? grid : rand_grid();
            #1;
            check("run.solver_start", 324'(bus_if.solver_start), 324'(0));
            check("run.solver_abort", 324'(bus_if.solver_abort),
                  324'((r == TO) && !(hit && (sol || gu))));
            check("run.rsp_valid",    324'(bus_if.rsp_valid),    324'(0));
            check("run.req_ready",    324'(bus_if.req_ready),    324'(0));
            fin = (r == TO) || (hit && (sol || gu));
        end
        m_busy = m_busy + 32'(r);

        tick();
        bus_if.solver_solution = 1'b0;
        bus_if.solver_give_up  = 1'b0;
        bus_if.solver_grid     = rand_grid();
        for (int d = 0; d <= rsp_delay; d++) begin
            bus_if.rsp_ready = (d == rsp_delay);
            #1;
            check("resp.rsp_valid",  324'(bus_if.rsp_valid),  324'(1));
            check("resp.rsp_id",     324'(bus_if.rsp_id),     324'(sb_q[0].id));
            check("resp.rsp_status", 324'(bus_if.rsp_status), 324'(sb_q[0].status));
            check("resp.rsp_grid",   bus_if.rsp_grid,         sb_q[0].grid);
            check("resp.solver_abort", 324'(bus_if.solver_abort), 324'(0));
            check("resp.req_ready",  324'(bus_if.req_ready),  324'(0));
            check_counters("resp");
            if (d < rsp_delay) tick();
        end
        e = sb_q.pop_front();
        if (e.status == 2'b01) begin
            if (m_solved != 10'h3FF) m_solved = m_solved + 10'd1;
        end else begin
            if (m_failed != 10'h3FF) m_failed = m_failed + 10'd1;
        end

        tick();
        bus_if.rsp_ready = 1'b0;
        #1;
        check("done.rsp_valid", 324'(bus_if.rsp_valid), 324'(0));
        check_counters("done");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus_if.req_valid       = 2'b00;
        bus_if.req_puzzle      = 648'd0;
        bus_if.solver_solution = 1'b0;
        bus_if.solver_give_up  = 1'b0;
        bus_if.solver_grid     = 324'd0;
        bus_if.rsp_ready       = 1'b0;
        model_last = 1'b1;
        m_solved   = 10'd0;
        m_failed   = 10'd0;
        m_busy     = 32'd0;
        rst        = 1'b1;
        tick();
        tick();
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // single request answered in the 5th RUN cycle
        do_job(2'b01, 1'b0, 5, 1'b1, 1'b0, 0);
        check("single.num_solved",  324'(bus_if.num_solved),  324'(1));
        check("single.busy_cycles", 324'(bus_if.busy_cycles), 324'(5));

        // watchdog expiry
        do_job(2'b10, 1'b0, 0, 1'b0, 1'b0, 0);
        check("timeout.num_failed", 324'(bus_if.num_failed), 324'(1));

        // contention with both requesters held valid
        for (int k = 0; k < 4; k++) do_job(2'b11, 1'b1, 2, 1'b1, 1'b0, 0);
        bus_if.req_valid = 2'b00;

        // solution, give-up and timeout coincide in the last RUN cycle
        do_job(2'b01, 1'b0, TO, 1'b1, 1'b1, 0);
        do_job(2'b10, 1'b0, 3, 1'b0, 1'b1, 0);

        // backpressure with both requesters waiting
        do_job(2'b11, 1'b1, 1, 1'b1, 1'b0, 10);
        bus_if.req_valid = 2'b00;

        // saturation of num_failed
        for (int k = 0; k < 1025; k++) do_job(2'b01, 1'b0, 1, 1'b0, 1'b1, 0);
        check("sat.num_failed", 324'(bus_if.num_failed), 324'(10'h3FF));

        // reset in the middle of RUN
        bus_if.req_valid = 2'b10;
        tick();
        bus_if.req_valid = 2'b00;
        tick();
        rst = 1'b1;
        #1;
        check("rstrun.in_run_abort", 324'(bus_if.solver_abort), 324'(0));
        tick();
        m_solved   = 10'd0;
        m_failed   = 10'd0;
        m_busy     = 32'd0;
        model_last = 1'b1;
        #1;
        check_reset_outputs();
        rst = 1'b0;
        do_job(2'b11, 1'b0, 1, 1'b1, 1'b0, 0);
        check("rstrun.tie_winner_solved", 324'(bus_if.num_solved), 324'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
